chip_gate_tester: RTL

- Parametrised successor to the single-type gate chip checkers.
- Tests any 74-series chip of NUM_GATES identical NUM_INPUTS-input gates.
- Gate function is selected at run time: NOT, AND, NAND, OR, NOR, XOR, XNOR.
- Drives an exhaustive input sweep with a programmable settle delay, then reports pass/fail, a per-gate failure mask and the first failing input vector to the checker top level.

---
 rtl/chip_gate_tester.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/chip_gate_tester.sv
// ---------------------------------------------------------------------------
// chip_gate_tester
//
// Exhaustive tester for 74-series chips built from NUM_GATES identical
// NUM_INPUTS-input gates. The gate function is picked at run time. The tester
// sweeps every input vector. Each vector is driven onto every gate at once.
// After a settle delay the synchronised chip outputs are compared with the
// expected function value. At the end the block reports pass/fail, a
// per-gate failure mask and the first vector that failed.
//
// Ports:
//   Clk          system clock
//   Reset        synchronous, active-high reset
//   Run          start request, accepted only while halted
//   Gate_Sel     function code, latched when Run is accepted
//                (0 NOT, 1 AND, 2 NAND, 3 OR, 4 NOR, 5 XOR, 6 XNOR, 7 invalid)
//   Drive        gate inputs to the chip; gate g input i = bit g*NUM_INPUTS+i
//   Sense        gate outputs from the chip; bit g = gate g
//   DISP_RSLT    result acknowledge; returns the block to halted from done
//   Done         high while the result is being presented
//   RSLT         1 = chip passed; valid while Done is high
//   Fail_Mask    bit g set if gate g mismatched on any vector
//   Fail_Vector  first vector on which any gate mismatched (0 if none)
// ---------------------------------------------------------------------------
module chip_gate_tester #(
  parameter int NUM_GATES     = 4,
  parameter int NUM_INPUTS    = 2,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                            Clk,
  input  logic                            Reset,
  input  logic                            Run,
  input  logic [2:0]                      Gate_Sel,
  output logic [NUM_GATES*NUM_INPUTS-1:0] Drive,
  input  logic [NUM_GATES-1:0]            Sense,
  input  logic                            DISP_RSLT,
  output logic                            Done,
  output logic                            RSLT,
  output logic [NUM_GATES-1:0]            Fail_Mask,
  output logic [NUM_INPUTS-1:0]           Fail_Vector
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]      SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0]      CNT_ONE     = CNT_W'(1);
  localparam logic [NUM_INPUTS-1:0] VEC_ONE     = NUM_INPUTS'(1);
  localparam logic [2:0]            CODE_BAD    = 3'd7;

  typedef enum logic [2:0] {
    HALTED,
    SET,
    APPLY,
    SETTLE,
    CHECK,
    DONE_S
  } state_t;

  state_t                  state;
  logic [2:0]              gate_code;
  logic [NUM_INPUTS-1:0]   vector;
  logic [CNT_W-1:0]        settle_cnt;
  logic                    fail_seen;
  logic [NUM_GATES-1:0]    sense_meta;
  logic [NUM_GATES-1:0]    sense_sync;
  logic                    expected_bit;
  logic [NUM_GATES-1:0]    mismatch;
  logic [NUM_GATES-1:0]    mask_next;

  // The chip outputs are asynchronous to us. Only the second flop is ever
  // compared, and only in CHECK. The settle delay of at least 3 cycles
  // leaves time for a new Drive value to reach sense_sync.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sense_meta <= '0;
      sense_sync <= '0;
    end else begin
      sense_meta <= Sense;
      sense_sync <= sense_meta;
    end
  end

  // This is the reference output for the current vector. Every gate on the
  // chip is identical, so one bit is replicated across all gates. Code 7
  // never reaches CHECK, so its value here does not matter.
  always_comb begin
    expected_bit = 1'b0;
    case (gate_code)
      3'd0:    expected_bit = ~vector[0];
      3'd1:    expected_bit = &vector;
      3'd2:    expected_bit = ~(&vector);
      3'd3:    expected_bit = |vector;
      3'd4:    expected_bit = ~(|vector);
      3'd5:    expected_bit = ^vector;
      3'd6:    expected_bit = ~(^vector);
      default: expected_bit = 1'b0;
    endcase
    mismatch  = sense_sync ^ {NUM_GATES{expected_bit}};
    mask_next = Fail_Mask | mismatch;
  end

  // This block holds the sweep sequencer and all of its registered outputs.
  // Each vector costs one APPLY cycle, SETTLE_CYCLES settle cycles and one
  // CHECK cycle. RSLT is computed from the mask value being written on the
  // final CHECK, so it is already valid on the first cycle of DONE_S.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= HALTED;
      gate_code   <= '0;
      vector      <= '0;
      settle_cnt  <= '0;
      fail_seen   <= 1'b0;
      Drive       <= '0;
      Done        <= 1'b0;
      RSLT        <= 1'b0;
      Fail_Mask   <= '0;
      Fail_Vector <= '0;
    end else begin
      case (state)
        HALTED: begin
          Drive <= '0;
          if (Run) begin
            gate_code <= Gate_Sel;
            state     <= SET;
          end
        end

        SET: begin
          vector      <= '0;
          Fail_Vector <= '0;
          fail_seen   <= 1'b0;
          if (gate_code == CODE_BAD) begin
            Fail_Mask <= '1;
            RSLT      <= 1'b0;
            Done      <= 1'b1;
            Drive     <= '0;
            state     <= DONE_S;
          end else begin
            Fail_Mask <= '0;
            state     <= APPLY;
          end
        end

        APPLY: begin
          Drive      <= {NUM_GATES{vector}};
          settle_cnt <= SETTLE_LOAD;
          state      <= SETTLE;
        end

        // The counter is loaded with SETTLE_CYCLES and the block leaves on
        // the cycle that shows 1, so it spends exactly SETTLE_CYCLES cycles
        // here.
        SETTLE: begin
          settle_cnt <= settle_cnt - CNT_ONE;
          if (settle_cnt == CNT_ONE) begin
            state <= CHECK;
          end
        end

        // The vector stops at all ones instead of wrapping. The all-ones
        // vector is therefore the end-of-sweep marker.
        CHECK: begin
          Fail_Mask <= mask_next;
          if ((|mismatch) && !fail_seen) begin
            Fail_Vector <= vector;
            fail_seen   <= 1'b1;
          end
          if (&vector) begin
            RSLT  <= (mask_next == '0);
            Done  <= 1'b1;
            Drive <= '0;
            state <= DONE_S;
          end else begin
            vector <= vector + VEC_ONE;
            state  <= APPLY;
          end
        end

        DONE_S: begin
          Drive <= '0;
          if (DISP_RSLT) begin
            Done  <= 1'b0;
            state <= HALTED;
          end
        end

        default: begin
          Drive <= '0;
          Done  <= 1'b0;
          state <= HALTED;
        end
      endcase
    end
  end

endmodule
